// File: rtl/pulse_train_gen.sv
// Pulse train generator: bursts of count pulses (0 = continuous), period/width latched at start.
// Define PULSE_TRAIN_GEN_ERR_EN to reject bad settings with an err strobe instead of clamping.
module pulse_train_gen #(
    parameter int PERIOD_W = 8,
    parameter int CNT_W    = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                stop,
    input  logic [PERIOD_W-1:0] period,
    input  logic [PERIOD_W-1:0] width,
    input  logic [CNT_W-1:0]    count,
    output logic                pulse,
    output logic                busy,
    output logic                done,
`ifdef PULSE_TRAIN_GEN_ERR_EN
    output logic                err,
`endif
    output logic [CNT_W-1:0]    pulses_sent
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HIGH,
        S_LOW,
        S_DONE
    } state_t;

    localparam logic [PERIOD_W-1:0] ONE = PERIOD_W'(1);
    localparam logic [PERIOD_W-1:0] TWO = PERIOD_W'(2);

    state_t              state_q, state_d;
    logic [PERIOD_W-1:0] per_q, per_d;
    logic [PERIOD_W-1:0] wid_q, wid_d;
    logic [CNT_W-1:0]    num_q, num_d;
    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0]    sent_q, sent_d;
    logic                pulse_q, pulse_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [PERIOD_W-1:0] p_eff;
    logic [PERIOD_W-1:0] w_eff;
    logic [PERIOD_W-1:0] low_len;
    logic [CNT_W-1:0]    sent_inc;
    logic                accept;

`ifdef PULSE_TRAIN_GEN_ERR_EN
    logic err_q, err_d;
    logic bad;
    assign bad    = (period < TWO) || (width == '0) || (width >= period);
    assign accept = start && !stop && !bad;
    assign err    = err_q;
`else
    assign accept = start && !stop;
`endif

    // Clamp so every accepted train has at least one HIGH and one LOW cycle.
    assign p_eff    = (period < TWO) ? TWO : period;
    assign w_eff    = (width == '0) ? ONE :
                      (width >= p_eff) ? (p_eff - ONE) : width;
    assign low_len  = per_q - wid_q;
    assign sent_inc = sent_q + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            per_q   <= '0;
            wid_q   <= '0;
            num_q   <= '0;
            cnt_q   <= '0;
            sent_q  <= '0;
            pulse_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef PULSE_TRAIN_GEN_ERR_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            per_q   <= per_d;
            wid_q   <= wid_d;
            num_q   <= num_d;
            cnt_q   <= cnt_d;
            sent_q  <= sent_d;
            pulse_q <= pulse_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef PULSE_TRAIN_GEN_ERR_EN
            err_q   <= err_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        per_d   = per_q;
        wid_d   = wid_q;
        num_d   = num_q;
        cnt_d   = cnt_q;
        sent_d  = sent_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_HIGH;
                    per_d   = p_eff;
                    wid_d   = w_eff;
                    num_d   = count;
                    cnt_d   = '0;
                    sent_d  = '0;
                end
            end
            S_HIGH: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else if (cnt_q == wid_q - ONE) begin
                    state_d = S_LOW;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            S_LOW: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else if (cnt_q == low_len - ONE) begin
                    cnt_d   = '0;
                    sent_d  = sent_inc;
                    state_d = (num_q != '0 && sent_inc == num_q) ? S_DONE : S_HIGH;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_comb begin
        pulse_d = (state_d == S_HIGH);
        busy_d  = (state_d == S_HIGH) || (state_d == S_LOW);
        done_d  = (state_d == S_DONE);
`ifdef PULSE_TRAIN_GEN_ERR_EN
        err_d   = (state_q == S_IDLE) && start && !stop && bad;
`endif
    end

    assign pulse       = pulse_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign pulses_sent = sent_q;

endmodule

// File: tb/tb_pulse_train_gen.sv
// Bench for pulse_train_gen: train-position reference model plus directed literal checks.
// Build with PULSE_TRAIN_GEN_ERR_EN defined to cover the err port.
module tb_pulse_train_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [7:0] period = '0;
    logic [7:0] width = '0;
    logic [3:0] count = '0;
    logic       pulse;
    logic       busy;
    logic       done;
    logic [3:0] pulses_sent;
`ifdef PULSE_TRAIN_GEN_ERR_EN
    logic       err;
`endif

    always #5 clk = ~clk;

    pulse_train_gen #(.PERIOD_W(8), .CNT_W(4)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .stop(stop),
        .period(period),
        .width(width),
        .count(count),
        .pulse(pulse),
        .busy(busy),
        .done(done),
`ifdef PULSE_TRAIN_GEN_ERR_EN
        .err(err),
`endif
        .pulses_sent(pulses_sent)
    );

    int checks = 0;
    int errors = 0;

    // Model: a running train is a time index t since the first HIGH cycle.
    bit m_act;
    int m_t, m_p, m_w, m_n, m_ps;
    bit m_err;

    function automatic void m_reset();
        m_act = 0; m_t = 0; m_p = 2; m_w = 1; m_n = 0; m_ps = 0; m_err = 0;
    endfunction

    task automatic m_step();
        int  p, w;
        bit  bad;
        m_err = 0;
        if (m_act) begin
            if (m_n != 0 && m_t == m_n * m_p) begin
                m_act = 0;
                m_ps  = m_n % 16;
            end else if (stop) begin
                m_act = 0;
                m_ps  = (m_t / m_p) % 16;
            end else begin
                m_t++;
            end
        end else if (start && !stop) begin
            p = (period < 2) ? 2 : int'(period);
            w = (width == 0) ? 1 : ((int'(width) >= p) ? p - 1 : int'(width));
            bad = 0;
`ifdef PULSE_TRAIN_GEN_ERR_EN
            bad = (period < 2) || (width == 0) || (width >= period);
`endif
            if (bad) begin
                m_err = 1;
            end else begin
                m_act = 1; m_t = 0; m_p = p; m_w = w; m_n = count; m_ps = 0;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic compare();
        bit ep, eb, ed;
        int eps;
        if (m_act && m_n != 0 && m_t == m_n * m_p) begin
            ep = 0; eb = 0; ed = 1; eps = m_n % 16;
        end else if (m_act) begin
            ep = (m_t % m_p) < m_w; eb = 1; ed = 0; eps = (m_t / m_p) % 16;
        end else begin
            ep = 0; eb = 0; ed = 0; eps = m_ps;
        end
        chk("pulse", pulse, ep);
        chk("busy", busy, eb);
        chk("done", done, ed);
        chk("pulses_sent", pulses_sent, eps[3:0]);
`ifdef PULSE_TRAIN_GEN_ERR_EN
        chk("err", err, m_err);
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        m_step();
        @(negedge clk);
        compare();
    endtask

    logic [11:0] pat;
    logic [7:0]  pat8;
    int          dcyc, bcnt, ps32, ps33;
    bit          nd;

    initial begin
        m_reset();
        repeat (2) @(negedge clk);
        compare();
        rst = 1'b1;
        tick();

        // Burst 4/1/3
        period = 4; width = 1; count = 3; start = 1;
        tick();
        start = 0; pat = '0; dcyc = 0; bcnt = 0;
        for (int i = 1; i <= 13; i++) begin
            if (i > 1) tick();
            if (i <= 12) pat = {pat[10:0], pulse};
            if (done && dcyc == 0) dcyc = i;
            bcnt += int'(busy);
        end
        chk("burst_pattern", pat, 12'b1000_1000_1000);
        chk("burst_done_cycle", dcyc, 13);
        chk("burst_sent", pulses_sent, 3);
        chk("burst_busy_cycles", bcnt, 12);
        tick(); tick();

        // Continuous 2/1/0 with wrap
        period = 2; width = 1; count = 0; start = 1;
        tick();
        start = 0; nd = 0; ps32 = -1; ps33 = -1;
        for (int i = 1; i <= 40; i++) begin
            if (i > 1) tick();
            if (i == 32) ps32 = pulses_sent;
            if (i == 33) ps33 = pulses_sent;
            nd |= done;
        end
        chk("cont_sent_15", ps32, 15);
        chk("cont_sent_wrap", ps33, 0);
        chk("cont_no_done", nd, 0);
        stop = 1;
        tick();
        stop = 0;
        chk("cont_stop_pulse", pulse, 0);
        chk("cont_stop_busy", busy, 0);
        tick();

        // Abort in 2nd HIGH of a count=5 train
        period = 4; width = 2; count = 5; start = 1;
        tick();
        start = 0;
        repeat (4) tick();
        chk("abort_in_high", pulse, 1);
        stop = 1;
        tick();
        stop = 0;
        chk("abort_busy", busy, 0);
        chk("abort_sent", pulses_sent, 1);
        nd = done;
        repeat (5) begin tick(); nd |= done; end
        chk("abort_no_done", nd, 0);

        // width == period == 8
        period = 8; width = 8; count = 1; start = 1;
        tick();
        start = 0;
`ifdef PULSE_TRAIN_GEN_ERR_EN
        chk("edge_err", err, 1);
        chk("edge_pulse", pulse, 0);
        tick();
        chk("edge_err_clear", err, 0);
        chk("edge_idle", busy, 0);
`else
        pat8 = '0;
        for (int i = 1; i <= 8; i++) begin
            if (i > 1) tick();
            pat8 = {pat8[6:0], pulse};
        end
        chk("edge_pattern", pat8, 8'b1111_1110);
        tick();
        chk("edge_done", done, 1);
`endif
        tick();

        // start and stop together in IDLE
        period = 4; width = 2; count = 2; start = 1; stop = 1;
        tick();
        start = 0; stop = 0;
        chk("contend_pulse", pulse, 0);
        chk("contend_busy", busy, 0);
        tick();

        // start and input changes while busy are ignored
        period = 6; width = 3; count = 2; start = 1;
        tick();
        start = 0;
        tick();
        start = 1; period = 2; width = 1; count = 0;
        repeat (3) tick();
        start = 0;
        repeat (12) tick();
        chk("busy_start_sent", pulses_sent, 2);
        chk("busy_start_idle", busy, 0);

        // Async reset mid-HIGH
        period = 10; width = 5; count = 0; start = 1;
        tick();
        start = 0;
        tick();
        rst = 0;
        #1;
        chk("rst_pulse_async", pulse, 0);
        chk("rst_busy_async", busy, 0);
        chk("rst_sent_async", pulses_sent, 0);
        m_reset();
        @(negedge clk);
        compare();
        rst = 1;
        repeat (3) tick();
        chk("rst_wait_start", busy, 0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            start  = ($urandom % 6) == 0;
            stop   = ($urandom % 60) == 0;
            period = ($urandom % 20 == 0) ? 8'($urandom_range(0, 40)) : 8'($urandom % 12);
            width  = 8'($urandom % 14);
            count  = 4'($urandom % 5);
            if ($urandom % 700 == 0) begin
                rst = 0;
                m_reset();
                @(negedge clk);
                compare();
                rst = 1;
            end else begin
                tick();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
